sdram_dwnld_router: RTL and testbench

- Routes the byte stream from the ROM loader (ioctl bus) into SDRAM programming requests.
- Strips a fixed-size file header; that header carries game config bytes, which other logic captures using the `header` flag.
- Selects the SDRAM bank from the byte address, forms a 16-bit word address plus an active-low byte mask, and diverts the PROM region to a one-cycle `prom_we` pulse.
- Sits between the HPS/ioctl download port and the SDRAM controller's programming port.

---
 rtl/sdram_dwnld_router.sv | 146 ++++++++++++++
 tb/tb_sdram_dwnld_router.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dwnld_router.sv
// sdram_dwnld_router: turns the ioctl byte stream into SDRAM programming
// requests, skipping the file header and diverting the PROM region.
//
// Build option: define DWNLD_HEADER_EN to strip HEADER leading bytes and
// flag them on `header`; without it `header` is 0 and part = ioctl_addr.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   downloading         download in progress
//   ioctl_addr/dout/wr  loader byte address, byte and one-cycle strobe
//   prog_addr/data/mask SDRAM word address (PROM byte offset), data, mask
//   prog_we, prog_rd    write request held until ack, read tied low
//   prog_ba             target bank
//   prom_we             one-cycle PROM write strobe
//   header              ioctl_addr lies inside the file header
//   sdram_ack           SDRAM accepted the request
module sdram_dwnld_router #(
    parameter int          HEADER     = 16,
    parameter logic [24:0] BA1_START  = 25'h0_0000,
    parameter logic [24:0] BA2_START  = 25'h0_0000,
    parameter logic [24:0] BA3_START  = 25'h0_0000,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
    parameter bit          SWAB       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        prog_rd,
    output logic [1:0]  prog_ba,
    output logic        prom_we,
    output logic        header,
    input  logic        sdram_ack
);

`ifdef DWNLD_HEADER_EN
    localparam logic [24:0] HDR = 25'(HEADER);
`else
    // Header stripping disabled: HEADER is ignored.
    localparam logic [24:0] HDR = 25'(HEADER) & 25'h0;
`endif

    logic [24:0] w_part;
    logic [25:0] w_dp, w_d3, w_d2, w_d1;
    logic [24:0] w_offset;
    logic [1:0]  w_ba;
    logic        w_prom;
    logic        w_lane;
    logic        w_wr;
    logic        w_sd_wr;
    logic        w_unused;

    logic [21:0] r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_mask;
    logic [1:0]  r_ba;
    logic        r_we;
    logic        r_prom_we;

`ifdef DWNLD_HEADER_EN
    assign header = downloading && (ioctl_addr < HDR);
`else
    assign header = 1'b0;
`endif

    assign w_part = ioctl_addr - HDR;

    // Borrow of a 26-bit subtract gives part < start; the low 25 bits
    // are the offset into that region.
    assign w_dp = {1'b0, w_part} - {1'b0, PROM_START};
    assign w_d3 = {1'b0, w_part} - {1'b0, BA3_START};
    assign w_d2 = {1'b0, w_part} - {1'b0, BA2_START};
    assign w_d1 = {1'b0, w_part} - {1'b0, BA1_START};

    // Highest region first, so equal starts resolve to the higher bank.
    always_comb begin
        w_prom   = 1'b0;
        w_ba     = 2'd0;
        w_offset = w_part;
        if (!w_dp[25]) begin
            w_prom = 1'b1;
        end else if (!w_d3[25]) begin
            w_ba     = 2'd3;
            w_offset = w_d3[24:0];
        end else if (!w_d2[25]) begin
            w_ba     = 2'd2;
            w_offset = w_d2[24:0];
        end else if (!w_d1[25]) begin
            w_ba     = 2'd1;
            w_offset = w_d1[24:0];
        end
    end

    assign w_lane  = w_offset[0] ^ SWAB;
    assign w_wr    = ioctl_wr && downloading && !header;
    assign w_sd_wr = w_wr && !w_prom;

    assign w_unused = ^{w_offset[24:23], w_dp[24:22]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= 22'd0;
            r_data    <= 16'd0;
            r_mask    <= 2'b11;
            r_ba      <= 2'd0;
            r_we      <= 1'b0;
            r_prom_we <= 1'b0;
        end else begin
            r_prom_we <= 1'b0;
            if (w_wr) begin
                r_data <= {ioctl_dout, ioctl_dout};
                if (w_prom) begin
                    r_addr    <= w_dp[21:0];
                    r_ba      <= 2'd0;
                    r_mask    <= 2'b10;
                    r_prom_we <= 1'b1;
                end else begin
                    r_addr <= w_offset[22:1];
                    r_ba   <= w_ba;
                    r_mask <= w_lane ? 2'b01 : 2'b10;
                end
            end
            // A new SDRAM write beats a same-cycle ack.
            if (w_sd_wr) begin
                r_we <= 1'b1;
            end else if (sdram_ack || !downloading) begin
                r_we <= 1'b0;
            end
        end
    end

    assign prog_addr = r_addr;
    assign prog_data = r_data;
    assign prog_mask = r_mask;
    assign prog_ba   = r_ba;
    assign prog_we   = r_we;
    assign prom_we   = r_prom_we;
    assign prog_rd   = 1'b0;

endmodule

// File: tb/tb_sdram_dwnld_router.sv
// tb_sdram_dwnld_router: two router instances (SWAB=0 and SWAB=1) driven
// in parallel and compared each cycle against a byte-level reference model.
module tb_sdram_dwnld_router;

    localparam logic [24:0] BA1  = 25'h80000;
    localparam logic [24:0] BA2  = 25'hC0000;
    localparam logic [24:0] BA3  = 25'hE0000;
    localparam logic [24:0] PROM = 25'h100000;
`ifdef DWNLD_HEADER_EN
    localparam int HDR_EFF = 16;
`else
    localparam int HDR_EFF = 0;
`endif
    localparam logic [24:0] HOFS = 25'(HDR_EFF);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic        sdram_ack = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;

    logic [21:0] pa0, pa1;
    logic [15:0] pd0, pd1;
    logic [1:0]  pm0, pm1, pb0, pb1;
    logic        pw0, pw1, pr0, pr1, pp0, pp1, hd0, hd1;
    logic [44:0] obs [2];

    int checks = 0;
    int errors = 0;

    logic [21:0] m_addr [2];
    logic [15:0] m_data [2];
    logic [1:0]  m_mask [2];
    logic [1:0]  m_ba   [2];
    logic        m_we   [2];
    logic        m_prom [2];

    always #5 clk = ~clk;

    sdram_dwnld_router #(
        .HEADER(16), .BA1_START(BA1), .BA2_START(BA2),
        .BA3_START(BA3), .PROM_START(PROM), .SWAB(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .prog_addr(pa0), .prog_data(pd0),
        .prog_mask(pm0), .prog_we(pw0), .prog_rd(pr0), .prog_ba(pb0),
        .prom_we(pp0), .header(hd0), .sdram_ack(sdram_ack)
    );

    sdram_dwnld_router #(
        .HEADER(16), .BA1_START(BA1), .BA2_START(BA2),
        .BA3_START(BA3), .PROM_START(PROM), .SWAB(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .prog_addr(pa1), .prog_data(pd1),
        .prog_mask(pm1), .prog_we(pw1), .prog_rd(pr1), .prog_ba(pb1),
        .prom_we(pp1), .header(hd1), .sdram_ack(sdram_ack)
    );

    assign obs[0] = {pa0, pd0, pm0, pb0, pw0, pp0, pr0};
    assign obs[1] = {pa1, pd1, pm1, pb1, pw1, pp1, pr1};

    function automatic logic [44:0] exp_vec(input int s);
        return {m_addr[s], m_data[s], m_mask[s], m_ba[s],
                m_we[s], m_prom[s], 1'b0};
    endfunction

    function automatic bit exp_hdr();
        return downloading && (int'(ioctl_addr) < HDR_EFF);
    endfunction

    // Reference: what the outputs should hold after the coming edge.
    task automatic model_step();
        logic [24:0] starts [4];
        logic [24:0] part, off;
        bit          new_sd;
        int          b;
        starts = '{25'h0, BA1, BA2, BA3};
        part = ioctl_addr - HOFS;
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_addr[s] = '0; m_data[s] = '0; m_mask[s] = 2'b11;
                m_ba[s] = '0; m_we[s] = 1'b0; m_prom[s] = 1'b0;
            end else begin
                new_sd = 1'b0;
                m_prom[s] = 1'b0;
                if (ioctl_wr && downloading && !exp_hdr()) begin
                    m_data[s] = {ioctl_dout, ioctl_dout};
                    if (part >= PROM) begin
                        off = part - PROM;
                        m_addr[s] = off[21:0];
                        m_ba[s] = 2'd0;
                        m_mask[s] = 2'b10;
                        m_prom[s] = 1'b1;
                    end else begin
                        b = 3;
                        while (b > 0 && part < starts[b]) b--;
                        off = part - starts[b];
                        m_addr[s] = off[22:1];
                        m_ba[s] = 2'(b);
                        m_mask[s] = (off[0] ^ (s == 1)) ? 2'b01 : 2'b10;
                        new_sd = 1'b1;
                    end
                end
                if (new_sd) m_we[s] = 1'b1;
                else if (sdram_ack || !downloading) m_we[s] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit dl, input bit wr, input logic [24:0] a,
                         input logic [7:0] d, input bit ack);
        downloading = dl;
        ioctl_wr = wr;
        ioctl_addr = a;
        ioctl_dout = d;
        sdram_ack = ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, HOFS + 25'd5, 8'h3C, 0);
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL reset inst%0d got %h want %h",
                         s, obs[s], exp_vec(s));
            end
        end
        checks++;
        if ({pw0, pp0, pm0, pr0} !== {1'b0, 1'b0, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals got %b want 00110",
                     {pw0, pp0, pm0, pr0});
        end
        rst = 1'b0;
        drive(1, 0, '0, '0, 0);
        tick();
    endtask

    task automatic test_header();
        drive(1, 1, 25'd3, 8'h05, 0);
        #1;
        checks++;
        if ({hd0, hd1} !== {2{exp_hdr()}}) begin
            errors++;
            $display("FAIL header_flag got %b want %b",
                     {hd0, hd1}, {2{exp_hdr()}});
        end
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL header_write inst%0d got %h want %h",
                         s, obs[s], exp_vec(s));
            end
        end
        drive(1, 0, '0, '0, 1);
        tick();
    endtask

    task automatic test_bank_swab();
        drive(1, 1, HOFS + BA1 + 25'd3, 8'hA5, 0);
        tick();
        checks++;
        if ({pb1, pa1, pd1, pm1, pw1} !==
            {2'd1, 22'd1, 16'hA5A5, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL bank1_swab got %h want %h",
                     {pb1, pa1, pd1, pm1, pw1},
                     {2'd1, 22'd1, 16'hA5A5, 2'b10, 1'b1});
        end
        drive(1, 0, HOFS + BA1 + 25'd3, 8'hA5, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL we_hold c%0d inst%0d got %h want %h",
                             c, s, obs[s], exp_vec(s));
                end
            end
        end
        sdram_ack = 1'b1;
        #1;
        checks++;
        if ({pw0, pw1} !== 2'b11) begin
            errors++;
            $display("FAIL we_at_ack got %b want 11", {pw0, pw1});
        end
        tick();
        sdram_ack = 1'b0;
        checks++;
        if ({pw0, pw1} !== 2'b00) begin
            errors++;
            $display("FAIL we_after_ack got %b want 00", {pw0, pw1});
        end
    endtask

    task automatic test_lanes();
        drive(1, 1, HOFS + 25'd2, 8'h11, 0);
        tick();
        checks++;
        if ({pb0, pa0, pm0} !== {2'd0, 22'd1, 2'b10}) begin
            errors++;
            $display("FAIL lane_even got %h want %h",
                     {pb0, pa0, pm0}, {2'd0, 22'd1, 2'b10});
        end
        drive(1, 1, HOFS + 25'd3, 8'h22, 0);
        tick();
        checks++;
        if ({pm0, pm1} !== {2'b01, 2'b10}) begin
            errors++;
            $display("FAIL lane_odd got %b want 0110", {pm0, pm1});
        end
        drive(1, 0, '0, '0, 1);
        tick();
    endtask

    task automatic test_prom();
        drive(1, 1, HOFS + PROM + 25'h123, 8'h77, 0);
        tick();
        checks++;
        if ({pp0, pa0, pw0, pm0, pb0} !==
            {1'b1, 22'h123, 1'b0, 2'b10, 2'd0}) begin
            errors++;
            $display("FAIL prom_write got %h want %h",
                     {pp0, pa0, pw0, pm0, pb0},
                     {1'b1, 22'h123, 1'b0, 2'b10, 2'd0});
        end
        drive(1, 0, '0, '0, 0);
        tick();
        checks++;
        if ({pp0, pp1, pw0} !== 3'b000) begin
            errors++;
            $display("FAIL prom_one_cycle got %b want 000",
                     {pp0, pp1, pw0});
        end
    endtask

    task automatic test_drop();
        drive(1, 1, HOFS + BA2 + 25'd9, 8'h5A, 0);
        tick();
        drive(0, 0, '0, '0, 0);
        tick();
        checks++;
        if ({pw0, pw1} !== 2'b00) begin
            errors++;
            $display("FAIL drop_dl got %b want 00", {pw0, pw1});
        end
        drive(0, 1, HOFS + BA3 + 25'd6, 8'hEE, 0);
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL idle_write inst%0d got %h want %h",
                         s, obs[s], exp_vec(s));
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, HOFS + 25'd4, 8'h01, 0);
        tick();
        drive(1, 1, HOFS + 25'd7, 8'h02, 1);
        tick();
        checks++;
        if ({pw0, pa0, pd0} !== {1'b1, 22'd3, 16'h0202}) begin
            errors++;
            $display("FAIL ack_and_write got %h want %h",
                     {pw0, pa0, pd0}, {1'b1, 22'd3, 16'h0202});
        end
        drive(1, 0, '0, '0, 1);
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== exp_vec(s)) begin
                errors++;
                $display("FAIL b2b_clear inst%0d got %h want %h",
                         s, obs[s], exp_vec(s));
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] bases [5];
        logic [24:0] a;
        bases = '{25'h0, BA1, BA2, BA3, PROM};
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0)
                a = 25'($urandom_range(0, 24));
            else
                a = HOFS + bases[$urandom_range(0, 4)]
                    + 25'($urandom_range(0, 255));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                  a, 8'($urandom), $urandom_range(0, 3) == 0);
            #1;
            checks++;
            if ({hd0, hd1} !== {2{exp_hdr()}}) begin
                errors++;
                $display("FAIL rand_hdr i%0d got %b want %b",
                         i, {hd0, hd1}, {2{exp_hdr()}});
            end
            tick();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL rand i%0d inst%0d got %h want %h",
                             i, s, obs[s], exp_vec(s));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_header();
        test_bank_swab();
        test_lanes();
        test_prom();
        test_drop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
